snoop_bus_arbiter: RTL and testbench

Parametrised shared-bus arbiter and snoop broadcaster for NUM_CORES processor tiles, each exposing a `req_core`/`grant` handshake and BusRd/BusUpgr/BusRdX/BusNoN operations. It grants the bus to one core at a time using round-robin priority, registers the owner's transaction and broadcasts it to all tiles. It then gathers the snoop hit responses and returns the OR of the other cores' hits to the owner. A grant-hold timeout stops a core that is idle on the bus from starving the others.

---
 rtl/snoop_bus_arbiter.sv | 157 +++++++++++++++
 tb/tb_snoop_bus_arbiter.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/snoop_bus_arbiter.sv
// Round-robin shared-bus arbiter with snoop broadcast, hit gathering and a
// grant-hold timeout that frees the bus from an idle owner.
module snoop_bus_arbiter #(
   parameter  int NUM_CORES = 2,
   parameter  int ADDR_W    = 32,
   parameter  int DATA_W    = 32,
   parameter  int HOLD_MAX  = 8,
   localparam int OW        = (NUM_CORES > 2) ? $clog2(NUM_CORES) : 1
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic [NUM_CORES-1:0]        req_core,
   input  logic [NUM_CORES-1:0]        stall_in,
   input  logic [2*NUM_CORES-1:0]      bus_operation_in,
   input  logic [ADDR_W*NUM_CORES-1:0] bus_address_in,
   input  logic [DATA_W*NUM_CORES-1:0] bus_data_in,
   input  logic [NUM_CORES-1:0]        cache_hit_in,
   output logic [NUM_CORES-1:0]        grant,
   output logic [OW-1:0]               owner,
   output logic [1:0]                  bus_operation_out,
   output logic [ADDR_W-1:0]           bus_address_out,
   output logic [DATA_W-1:0]           bus_data_out,
   output logic                        snoop_valid,
   output logic [NUM_CORES-1:0]        cache_hit_out,
   output logic                        timeout_err
);

   localparam int HW = (HOLD_MAX > 0) ? $clog2(HOLD_MAX + 1) : 1;
   localparam logic [HW-1:0] HOLD_LAST = (HOLD_MAX > 0) ? HW'(HOLD_MAX - 1) : '0;
   localparam logic [1:0] OP_NON = 2'b11;

   typedef enum logic [1:0] {S_IDLE, S_GRANT, S_SNOOP, S_RELEASE} state_t;

   state_t                state_q, state_d;
   logic [OW-1:0]         last_owner, last_owner_d, owner_d;
   logic [NUM_CORES-1:0]  grant_d, hit_d;
   logic [1:0]            op_d, prev_op, prev_op_d;
   logic [ADDR_W-1:0]     addr_d;
   logic [DATA_W-1:0]     data_d;
   logic                  snoop_valid_d, timeout_d;
   logic [HW-1:0]         hold_cnt, hold_d;

   logic [NUM_CORES-1:0]  own_mask;
   logic [1:0]            own_op;
   logic [ADDR_W-1:0]     own_addr;
   logic [DATA_W-1:0]     own_data;
   logic                  accept, timeout_hit;
   logic [OW-1:0]         pick;
   logic                  pick_found;

   assign own_mask = NUM_CORES'(1) << owner;
   assign own_op   = bus_operation_in[2*int'(owner) +: 2];
   assign own_addr = bus_address_in[ADDR_W*int'(owner) +: ADDR_W];
   assign own_data = bus_data_in[DATA_W*int'(owner) +: DATA_W];

   // A transaction starts only on a BusNoN -> real-op edge from the owner.
   assign accept = (own_op != OP_NON) && (prev_op == OP_NON);

   assign timeout_hit = (HOLD_MAX != 0) && (hold_cnt == HOLD_LAST) &&
                        !stall_in[owner] && (|(req_core & ~own_mask));

   // Descending scan so the nearest requester after last_owner is kept last.
   always_comb begin
      pick_found = 1'b0;
      pick       = '0;
      for (int i = NUM_CORES; i >= 1; i--) begin
         int idx;
         idx = (int'(last_owner) + i) % NUM_CORES;
         if (req_core[idx]) begin
            pick_found = 1'b1;
            pick       = OW'(idx);
         end
      end
   end

   always_comb begin
      state_d       = state_q;
      grant_d       = grant;
      owner_d       = owner;
      last_owner_d  = last_owner;
      op_d          = bus_operation_out;
      addr_d        = bus_address_out;
      data_d        = bus_data_out;
      snoop_valid_d = 1'b0;
      hit_d         = cache_hit_out;
      timeout_d     = 1'b0;
      hold_d        = hold_cnt;
      prev_op_d     = own_op;
      case (state_q)
         S_IDLE: begin
            if (pick_found) begin
               grant_d      = NUM_CORES'(1) << pick;
               owner_d      = pick;
               last_owner_d = pick;
               hold_d       = '0;
               prev_op_d    = OP_NON;
               state_d      = S_GRANT;
            end
         end
         S_GRANT: begin
            if (accept) begin
               op_d          = own_op;
               addr_d        = own_addr;
               data_d        = own_data;
               snoop_valid_d = 1'b1;
               hold_d        = '0;
               state_d       = S_SNOOP;
            end else if (!req_core[owner] || timeout_hit) begin
               grant_d   = '0;
               hit_d     = '0;
               timeout_d = timeout_hit;
               state_d   = S_RELEASE;
            end else if (hold_cnt != HOLD_LAST) begin
               hold_d = hold_cnt + HW'(1);
            end
         end
         S_SNOOP: begin
            op_d         = OP_NON;
            hit_d        = '0;
            hit_d[owner] = |(cache_hit_in & ~own_mask);
            state_d      = S_GRANT;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q           <= S_IDLE;
         grant             <= '0;
         owner             <= '0;
         last_owner        <= OW'(NUM_CORES - 1);
         bus_operation_out <= OP_NON;
         bus_address_out   <= '0;
         bus_data_out      <= '0;
         snoop_valid       <= 1'b0;
         cache_hit_out     <= '0;
         timeout_err       <= 1'b0;
         hold_cnt          <= '0;
         prev_op           <= OP_NON;
      end else begin
         state_q           <= state_d;
         grant             <= grant_d;
         owner             <= owner_d;
         last_owner        <= last_owner_d;
         bus_operation_out <= op_d;
         bus_address_out   <= addr_d;
         bus_data_out      <= data_d;
         snoop_valid       <= snoop_valid_d;
         cache_hit_out     <= hit_d;
         timeout_err       <= timeout_d;
         hold_cnt          <= hold_d;
         prev_op           <= prev_op_d;
      end
   end

endmodule

// File: tb/tb_snoop_bus_arbiter.sv
// Directed bench for snoop_bus_arbiter: four tiles, HOLD_MAX = 4.
module tb_snoop_bus_arbiter;

   localparam int N  = 4;
   localparam int AW = 32;
   localparam int DW = 32;

   logic              clk = 1'b0;
   logic              reset;
   logic [N-1:0]      req_core, stall_in, cache_hit_in;
   logic [2*N-1:0]    bus_operation_in;
   logic [AW*N-1:0]   bus_address_in;
   logic [DW*N-1:0]   bus_data_in;
   logic [N-1:0]      grant, cache_hit_out;
   logic [1:0]        owner;
   logic [1:0]        bus_operation_out;
   logic [AW-1:0]     bus_address_out;
   logic [DW-1:0]     bus_data_out;
   logic              snoop_valid, timeout_err;

   int checks = 0;
   int errors = 0;

   snoop_bus_arbiter #(.NUM_CORES(N), .ADDR_W(AW), .DATA_W(DW), .HOLD_MAX(4)) u_dut (
      .clk(clk), .reset(reset), .req_core(req_core), .stall_in(stall_in),
      .bus_operation_in(bus_operation_in), .bus_address_in(bus_address_in),
      .bus_data_in(bus_data_in), .cache_hit_in(cache_hit_in), .grant(grant),
      .owner(owner), .bus_operation_out(bus_operation_out),
      .bus_address_out(bus_address_out), .bus_data_out(bus_data_out),
      .snoop_valid(snoop_valid), .cache_hit_out(cache_hit_out),
      .timeout_err(timeout_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_op(input int core, input logic [1:0] op,
                           input logic [31:0] addr, input logic [31:0] data);
      bus_operation_in[2*core +: 2] = op;
      bus_address_in[AW*core +: AW] = addr;
      bus_data_in[DW*core +: DW]    = data;
   endtask

   task automatic check_reset_state(input string tag);
      chk({tag, "_grant"}, grant, 0);
      chk({tag, "_owner"}, owner, 0);
      chk({tag, "_op"},    bus_operation_out, 2'b11);
      chk({tag, "_addr"},  bus_address_out, 0);
      chk({tag, "_data"},  bus_data_out, 0);
      chk({tag, "_sv"},    snoop_valid, 0);
      chk({tag, "_hit"},   cache_hit_out, 0);
      chk({tag, "_to"},    timeout_err, 0);
   endtask

   task automatic do_reset();
      reset = 1'b0;
      req_core = '0;
      stall_in = '0;
      cache_hit_in = '0;
      bus_operation_in = '1;
      step();
      reset = 1'b1;
   endtask

   initial begin
      int gap;
      int exp_owner;
      reset            = 1'b0;
      req_core         = '0;
      stall_in         = '0;
      cache_hit_in     = '0;
      bus_operation_in = '1;
      bus_address_in   = '0;
      bus_data_in      = '0;
      step();
      step();
      check_reset_state("rst");
      reset = 1'b1;

      // Single requester with a hit from core1
      req_core = 4'b0001;
      step();
      chk("single_grant", grant, 4'b0001);
      chk("single_owner", owner, 0);
      drive_op(0, 2'b00, 32'h100, 32'hDEAD_BEEF);
      cache_hit_in = 4'b0010;
      step();
      chk("single_sv", snoop_valid, 1);
      chk("single_op", bus_operation_out, 2'b00);
      chk("single_addr", bus_address_out, 32'h100);
      chk("single_data", bus_data_out, 32'hDEAD_BEEF);
      drive_op(0, 2'b11, 32'h0, 32'h0);
      step();
      chk("single_hit", cache_hit_out, 4'b0001);
      chk("single_sv_off", snoop_valid, 0);
      chk("single_op_non", bus_operation_out, 2'b11);
      chk("single_addr_hold", bus_address_out, 32'h100);
      chk("single_grant_hold", grant, 4'b0001);

      // Back-to-back: held BusRdX gives one snoop; own hit is excluded
      cache_hit_in = 4'b0001;
      drive_op(0, 2'b10, 32'h200, 32'h2);
      step();
      chk("b2b_sv1", snoop_valid, 1);
      chk("b2b_op1", bus_operation_out, 2'b10);
      step();
      chk("b2b_sv_gap1", snoop_valid, 0);
      chk("b2b_own_hit", cache_hit_out, 4'b0000);
      step();
      chk("b2b_sv_gap2", snoop_valid, 0);
      drive_op(0, 2'b11, 32'h200, 32'h2);
      step();
      chk("b2b_sv_gap3", snoop_valid, 0);
      drive_op(0, 2'b01, 32'h300, 32'h3);
      step();
      chk("b2b_sv2", snoop_valid, 1);
      chk("b2b_op2", bus_operation_out, 2'b01);
      chk("b2b_addr2", bus_address_out, 32'h300);
      drive_op(0, 2'b11, 32'h0, 32'h0);
      step();

      // Drop request in the same cycle as an op: snoop first, then release
      drive_op(0, 2'b00, 32'h400, 32'h4);
      req_core = 4'b0000;
      step();
      chk("sim_sv", snoop_valid, 1);
      chk("sim_grant_in_snoop", grant, 4'b0001);
      drive_op(0, 2'b11, 32'h0, 32'h0);
      step();
      chk("sim_grant_back", grant, 4'b0001);
      step();
      chk("sim_release_grant", grant, 0);
      chk("sim_release_hit", cache_hit_out, 0);
      chk("sim_release_to", timeout_err, 0);
      step();
      chk("sim_idle_grant", grant, 0);

      // Round robin from reset: owners 0,1,2,3,0
      do_reset();
      req_core = 4'b1111;
      for (int k = 0; k < 5; k++) begin
         gap = 0;
         step();
         while (grant == 0 && gap < 20) begin
            gap++;
            step();
         end
         exp_owner = k % 4;
         chk("rr_owner", owner, exp_owner);
         chk("rr_grant", grant, 64'(1) << exp_owner);
         if (k > 0) chk("rr_gap", gap, 1);
         drive_op(exp_owner, 2'b00, 32'h1000 + k, 32'h0);
         step();
         chk("rr_onehot", $onehot0(grant), 1);
         drive_op(exp_owner, 2'b11, 32'h0, 32'h0);
         req_core[exp_owner] = 1'b0;
         step();
         chk("rr_onehot_g", $onehot0(grant), 1);
         step();
         chk("rr_release", grant, 0);
         req_core[exp_owner] = 1'b1;
      end

      // Timeout with core1 waiting, stall low
      do_reset();
      req_core = 4'b0001;
      step();
      chk("to_grant0", grant, 4'b0001);
      req_core = 4'b0011;
      for (int c = 0; c < 3; c++) begin
         step();
         chk("to_hold_grant", grant, 4'b0001);
         chk("to_hold_err", timeout_err, 0);
      end
      step();
      chk("to_err_pulse", timeout_err, 1);
      chk("to_release_grant", grant, 0);
      step();
      chk("to_err_clear", timeout_err, 0);
      step();
      chk("to_next_grant", grant, 4'b0010);
      chk("to_next_owner", owner, 1);

      // Same again but the owner is stalled: no forced release
      stall_in = 4'b0010;
      for (int c = 0; c < 8; c++) begin
         step();
         chk("stall_grant", grant, 4'b0010);
         chk("stall_err", timeout_err, 0);
      end

      // Reset mid-SNOOP, then core0 wins the tie
      do_reset();
      req_core = 4'b0001;
      step();
      drive_op(0, 2'b10, 32'h500, 32'h5);
      step();
      chk("rs_sv", snoop_valid, 1);
      reset = 1'b0;
      step();
      check_reset_state("rs");
      reset = 1'b1;
      drive_op(0, 2'b11, 32'h0, 32'h0);
      req_core = 4'b0011;
      step();
      chk("rs_tie_grant", grant, 4'b0001);
      chk("rs_tie_owner", owner, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
